// File: rtl/spi_tx_packet_scheduler_if.sv
// Request/ack and byte-stream bundle between the FIB output logic,
// the packet scheduler and the SPI transmitter.
interface spi_tx_packet_scheduler_if #(
  parameter int META_WIDTH    = 8,
  parameter int PREFIX_WIDTH  = 64,
  parameter int CONTENT_WIDTH = 256
);
  localparam int IW = META_WIDTH + PREFIX_WIDTH;
  localparam int DW = IW + CONTENT_WIDTH;

  logic          interest_req;
  logic [IW-1:0] interest_packet;
  logic          interest_ack;
  logic          data_req;
  logic [DW-1:0] data_packet;
  logic          data_ack;
  logic          tx_ready;
  logic          tx_start;
  logic          tx_is_data;
  logic          tx_valid;
  logic [7:0]    tx_byte;
  logic          busy;

  modport master (
    output interest_req, interest_packet,
    output data_req, data_packet, tx_ready,
    input  interest_ack, data_ack,
    input  tx_start, tx_is_data, tx_valid,
    input  tx_byte, busy
  );

  modport slave (
    input  interest_req, interest_packet,
    input  data_req, data_packet, tx_ready,
    output interest_ack, data_ack,
    output tx_start, tx_is_data, tx_valid,
    output tx_byte, busy
  );
endinterface

// File: rtl/spi_tx_packet_scheduler.sv
// Round-robin arbiter between interest and data packets that
// serializes the granted packet MSB-first onto the SPI byte channel.
module spi_tx_packet_scheduler #(
  parameter int META_WIDTH    = 8,
  parameter int PREFIX_WIDTH  = 64,
  parameter int CONTENT_WIDTH = 256
) (
  input  logic clk,
  input  logic rst,
  spi_tx_packet_scheduler_if.slave bus
);
  localparam int IW     = META_WIDTH + PREFIX_WIDTH;
  localparam int DW     = IW + CONTENT_WIDTH;
  localparam int IBYTES = IW / 8;
  localparam int DBYTES = DW / 8;
  localparam int CW     = $clog2(DBYTES + 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    SEND
  } state_t;

  state_t        state, state_nx;
  logic [DW-1:0] shift, shift_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          last_data, last_data_nx;
  logic          is_data, is_data_nx;
  logic          iack, iack_nx;
  logic          dack, dack_nx;
  logic          start, start_nx;
  logic          valid, valid_nx;
  logic [7:0]    byte_q, byte_nx;
  logic          grant_i, grant_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift     <= '0;
      cnt       <= '0;
      last_data <= 1'b1;
      is_data   <= 1'b0;
      iack      <= 1'b0;
      dack      <= 1'b0;
      start     <= 1'b0;
      valid     <= 1'b0;
      byte_q    <= '0;
    end else begin
      state     <= state_nx;
      shift     <= shift_nx;
      cnt       <= cnt_nx;
      last_data <= last_data_nx;
      is_data   <= is_data_nx;
      iack      <= iack_nx;
      dack      <= dack_nx;
      start     <= start_nx;
      valid     <= valid_nx;
      byte_q    <= byte_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    shift_nx     = shift;
    cnt_nx       = cnt;
    last_data_nx = last_data;
    is_data_nx   = is_data;
    iack_nx      = 1'b0;
    dack_nx      = 1'b0;
    start_nx     = 1'b0;
    valid_nx     = 1'b0;
    byte_nx      = byte_q;
    // on a tie the type not served last time wins
    grant_i = bus.interest_req && (!bus.data_req || last_data);
    grant_d = bus.data_req && (!bus.interest_req || !last_data);
    unique case (state)
      IDLE: begin
        if (grant_i) begin
          shift_nx     = {bus.interest_packet, {CONTENT_WIDTH{1'b0}}};
          cnt_nx       = CW'(IBYTES);
          is_data_nx   = 1'b0;
          last_data_nx = 1'b0;
          iack_nx      = 1'b1;
          state_nx     = START;
        end else if (grant_d) begin
          shift_nx     = bus.data_packet;
          cnt_nx       = CW'(DBYTES);
          is_data_nx   = 1'b1;
          last_data_nx = 1'b1;
          dack_nx      = 1'b1;
          state_nx     = START;
        end
      end
      START: begin
        start_nx = 1'b1;
        state_nx = SEND;
      end
      SEND: begin
        // counter hits zero on the edge that drives the last byte
        if (cnt == '0) begin
          state_nx = IDLE;
        end else if (bus.tx_ready) begin
          valid_nx = 1'b1;
          byte_nx  = shift[DW-1 -: 8];
          shift_nx = shift << 8;
          cnt_nx   = cnt - CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.interest_ack = iack;
  assign bus.data_ack     = dack;
  assign bus.tx_start     = start;
  assign bus.tx_is_data   = is_data;
  assign bus.tx_valid     = valid;
  assign bus.tx_byte      = byte_q;
  assign bus.busy         = (state != IDLE);
endmodule
